// File: rtl/regex_cpu_split_pkg.sv
// Shared definitions for the regex thread executor: instruction
// encoding, opcode set and controller state type.
package regex_cpu_split_pkg;

    localparam int OPCODE_WIDTH           = 3;
    localparam int MEMORY_WIDTH_DEFAULT   = 20;
    localparam int INSTRUCTION_DATA_WIDTH = MEMORY_WIDTH_DEFAULT - OPCODE_WIDTH;

    // Opcode occupies the top OPCODE_WIDTH bits of an instruction word.
    // Encoding 3'd7 is unassigned and kills the thread.
    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ACCEPT         = 3'd0,
        OP_ACCEPT_PARTIAL = 3'd1,
        OP_MATCH_CHAR     = 3'd2,
        OP_NOT_MATCH      = 3'd3,
        OP_MATCH_ANY      = 3'd4,
        OP_JMP            = 3'd5,
        OP_SPLIT          = 3'd6
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/regex_cpu_split_decoder.sv
// Combinational instruction decode: classifies the current instruction
// against the lane character and terminator of the running thread.
module regex_cpu_split_decoder
    import regex_cpu_split_pkg::*;
#(
    parameter int CHARACTER_WIDTH = 8
) (
    input  logic [OPCODE_WIDTH-1:0]    opcode,
    input  logic [CHARACTER_WIDTH-1:0] instr_char,
    input  logic [CHARACTER_WIDTH-1:0] ch,
    input  logic                       eos,
    output logic                       match,
    output logic                       consume,
    output logic                       accept,
    output logic                       fork_thread,
    output logic                       jump
);

    // Decode opcode into control flags; unknown opcodes leave all flags low.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        match       = 1'b0;
        consume     = 1'b0;
        accept      = 1'b0;
        fork_thread = 1'b0;
        jump        = 1'b0;
        case (opcode_t'(opcode))
            OP_ACCEPT:         accept = eos;
            OP_ACCEPT_PARTIAL: accept = 1'b1;
            OP_MATCH_CHAR: begin
                consume = 1'b1;
                match   = !eos && (ch == instr_char);
            end
            OP_NOT_MATCH: begin
                consume = 1'b1;
                match   = !eos && (ch != instr_char);
            end
            OP_MATCH_ANY: begin
                consume = 1'b1;
                match   = !eos;
            end
            OP_JMP:            jump        = 1'b1;
            OP_SPLIT:          fork_thread = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/regex_cpu_split.sv
// Regex thread executor with JMP/SPLIT support. Fetches instructions for
// one thread at a time, runs non-consuming instructions internally and
// emits surviving/forked threads or pulses accepts.
// Optional statistics counters: define REGEX_CPU_SPLIT_STATS_EN.
module regex_cpu_split
    import regex_cpu_split_pkg::*;
#(
    parameter int PC_WIDTH           = 9,
    parameter int CC_ID_BITS         = 2,
    parameter int CHARACTER_WIDTH    = 8,
    parameter int MEMORY_WIDTH       = 20,
    parameter int MEMORY_ADDR_WIDTH  = 11,
    parameter int MAX_INTERNAL_STEPS = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0] current_characters,
    input  logic [2**CC_ID_BITS-1:0]                 end_of_string,
    input  logic                                     input_pc_valid,
    output logic                                     input_pc_ready,
    input  logic [CC_ID_BITS-1:0]                    input_cc_id,
    input  logic [PC_WIDTH-1:0]                      input_pc,
    output logic                                     memory_valid,
    input  logic                                     memory_ready,
    output logic [MEMORY_ADDR_WIDTH-1:0]             memory_addr,
    input  logic [MEMORY_WIDTH-1:0]                  memory_data,
    output logic                                     output_pc_valid,
    input  logic                                     output_pc_ready,
    output logic [PC_WIDTH-1:0]                      output_pc,
    output logic [CC_ID_BITS-1:0]                    output_cc_id,
    output logic                                     accepts
`ifdef REGEX_CPU_SPLIT_STATS_EN
    ,
    output logic [31:0]                              stat_instructions,
    output logic [31:0]                              stat_accepts
`endif
);

    localparam int LANES  = 2**CC_ID_BITS;
    localparam int STEP_W = $clog2(MAX_INTERNAL_STEPS + 1);

    state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q;
    logic [CC_ID_BITS-1:0]    cc_q;
    logic [STEP_W-1:0]        steps_q;
    logic [MEMORY_WIDTH-1:0]  instr_q;
    logic [PC_WIDTH-1:0]      out_pc_q;
    logic [CC_ID_BITS-1:0]    out_cc_q;
    logic                     fork_continue_q;

    logic [CHARACTER_WIDTH-1:0] lane_chars [LANES];
    logic [CHARACTER_WIDTH-1:0] ch;
    logic                       eos;
    logic [PC_WIDTH-1:0]        target;
    logic                       step_hit;
    logic dec_match, dec_consume, dec_accept, dec_fork, dec_jump;
    logic unused_instr_bits;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_chars[k] = current_characters[k*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    end

    assign ch       = lane_chars[cc_q];
    assign eos      = end_of_string[cc_q];
    assign target   = instr_q[PC_WIDTH-1:0];
    // The next non-consuming instruction would reach the step budget.
    assign step_hit = (steps_q == STEP_W'(MAX_INTERNAL_STEPS - 1));
    // Middle instruction bits are don't-care for every opcode.
    assign unused_instr_bits = ^instr_q;

    regex_cpu_split_decoder #(
        .CHARACTER_WIDTH(CHARACTER_WIDTH)
    ) u_decoder (
        .opcode      (instr_q[MEMORY_WIDTH-1 -: OPCODE_WIDTH]),
        .instr_char  (instr_q[CHARACTER_WIDTH-1:0]),
        .ch          (ch),
        .eos         (eos),
        .match       (dec_match),
        .consume     (dec_consume),
        .accept      (dec_accept),
        .fork_thread (dec_fork),
        .jump        (dec_jump)
    );

    assign input_pc_ready  = (state_q == ST_IDLE);
    assign memory_valid    = (state_q == ST_FETCH);
    assign memory_addr     = MEMORY_ADDR_WIDTH'(pc_q);
    assign output_pc_valid = (state_q == ST_EMIT);
    assign output_pc       = out_pc_q;
    assign output_cc_id    = out_cc_q;

    // State register; reset aborts any thread in flight.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (input_pc_valid) state_d = ST_FETCH;
            ST_FETCH: if (memory_ready)   state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec_fork)                      state_d = ST_EMIT;
                else if (dec_jump)                 state_d = step_hit ? ST_IDLE : ST_FETCH;
                else if (dec_consume && dec_match) state_d = ST_EMIT;
                else                               state_d = ST_IDLE;
            end
            ST_EMIT:  if (output_pc_ready) state_d = fork_continue_q ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Thread context, instruction register, output thread and accept pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q            <= '0;
            cc_q            <= '0;
            steps_q         <= '0;
            instr_q         <= '0;
            out_pc_q        <= '0;
            out_cc_q        <= '0;
            fork_continue_q <= 1'b0;
            accepts         <= 1'b0;
        end else begin
            accepts <= (state_q == ST_EXEC) && dec_accept;
            case (state_q)
                ST_IDLE: if (input_pc_valid) begin
                    pc_q    <= input_pc;
                    cc_q    <= input_cc_id;
                    steps_q <= '0;
                end
                ST_WAIT: instr_q <= memory_data;
                ST_EXEC: begin
                    if (dec_jump) begin
                        pc_q    <= target;
                        steps_q <= steps_q + 1'b1;
                    end
                    if (dec_fork) begin
                        out_pc_q        <= target;
                        out_cc_q        <= cc_q;
                        pc_q            <= pc_q + 1'b1;
                        steps_q         <= steps_q + 1'b1;
                        fork_continue_q <= !step_hit;
                    end
                    if (dec_consume) begin
                        out_pc_q        <= pc_q + 1'b1;
                        out_cc_q        <= cc_q + 1'b1;
                        fork_continue_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REGEX_CPU_SPLIT_STATS_EN
    // Saturating counters of executed instructions and accept pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_instructions <= '0;
            stat_accepts      <= '0;
        end else begin
            if (state_q == ST_EXEC && stat_instructions != '1)
                stat_instructions <= stat_instructions + 1'b1;
            if (accepts && stat_accepts != '1)
                stat_accepts <= stat_accepts + 1'b1;
        end
    end
`endif

endmodule

// File: doc/regex_cpu_split.md
Name: regex_cpu_split

Overview:
- Next-generation regex thread executor, parametrised in character lanes, with a richer instruction set than the accept-only core.
- Takes one thread (pc, cc_id) from the dispatcher and fetches instructions from shared instruction memory.
- Runs non-consuming instructions (JMP, SPLIT) internally until a consuming instruction, an accept or a failure ends the thread.
- Emits surviving or forked threads on an output pc stream, and pulses accepts.

Parameters:
- PC_WIDTH, 9: program counter width.
- CC_ID_BITS, 2: log2 of the number of character lanes.
- CHARACTER_WIDTH, 8: bits per character.
- MEMORY_WIDTH, 20: instruction word width; equals OPCODE_WIDTH + INSTRUCTION_DATA_WIDTH.
- MEMORY_ADDR_WIDTH, 11: memory address width; must be >= PC_WIDTH.
- MAX_INTERNAL_STEPS, 16: maximum consecutive non-consuming instructions per thread before the thread is killed.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- current_characters  in  (2**CC_ID_BITS)*CHARACTER_WIDTH  one character per lane; lane k occupies bits [k*CHARACTER_WIDTH +: CHARACTER_WIDTH].
- end_of_string  in  2**CC_ID_BITS  per-lane terminator flag.
- input_pc_valid / input_pc_ready  in / out  1  thread input handshake.
- input_cc_id  in  CC_ID_BITS  lane of the input thread.
- input_pc  in  PC_WIDTH  pc of the input thread.
- memory_valid  out  1  fetch request.
- memory_ready  in  1  fetch grant.
- memory_addr  out  MEMORY_ADDR_WIDTH  fetch address, pc zero-extended.
- memory_data  in  MEMORY_WIDTH  instruction; valid on the cycle after the grant.
- output_pc_valid / output_pc_ready  out / in  1  thread output handshake.
- output_pc  out  PC_WIDTH  output thread pc.
- output_cc_id  out  CC_ID_BITS  output thread lane.
- accepts  out  1  one-cycle accept pulse.

Behaviour:
- Reset: state IDLE; input_pc_ready=1; memory_valid=0; output_pc_valid=0; accepts=0; pc, cc_id and step counter =0.
- Reset asserted mid-thread aborts the thread immediately; nothing is emitted.
- IDLE: input_pc_ready=1. On valid&ready, latch pc and cc_id, clear the step counter, go to FETCH.
- FETCH: memory_valid=1, memory_addr=pc. When memory_ready is sampled high, go to WAIT.
- WAIT: capture memory_data into the instruction register at the next edge, go to EXEC.
- EXEC: decode opcode = top OPCODE_WIDTH bits; c = data[CHARACTER_WIDTH-1:0]; t = data[PC_WIDTH-1:0]; ch and eos come from lane cc_id.
- ACCEPT: accepts=1 next cycle if eos, else no pulse. Go to IDLE.
- ACCEPT_PARTIAL: accepts=1 next cycle unconditionally. Go to IDLE.
- MATCH_CHAR: if !eos && ch==c, emit (pc+1, cc_id+1). Otherwise drop the thread and go to IDLE.
- NOT_MATCH: if !eos && ch!=c, emit (pc+1, cc_id+1). Otherwise drop the thread and go to IDLE.
- MATCH_ANY: if !eos, emit (pc+1, cc_id+1). Otherwise drop the thread and go to IDLE.
- JMP: pc<=t, go to FETCH. Non-consuming; counts one step.
- SPLIT: emit (t, cc_id) on the output, then continue with pc<=pc+1 in FETCH. Non-consuming; counts one step.
- Unknown opcode: drop the thread and go to IDLE.
- EMIT state: output_pc_valid=1 held with stable output_pc and output_cc_id until output_pc_ready. Then go to IDLE (consuming instructions) or FETCH (SPLIT).
- Step limit: when a non-consuming instruction would bring the step counter to MAX_INTERNAL_STEPS, drop the thread and go to IDLE. A SPLIT at the limit still emits its fork first.
- Arithmetic: pc+1 wraps mod 2**PC_WIDTH; cc_id+1 wraps mod 2**CC_ID_BITS.
- Accept timing: accepts is registered, asserted exactly one cycle after EXEC, never on two consecutive cycles.
- Ready gating: input_pc_ready=0 in every state except IDLE.
- Latency: input handshake to accepts is 4 cycles with memory_ready granted immediately.

Optional Feature:
- Macro: REGEX_CPU_SPLIT_STATS_EN.
- When defined, adds outputs stat_instructions and stat_accepts, each 32 bits.
- stat_instructions counts EXEC cycles; stat_accepts counts accept pulses.
- Both counters saturate at all-ones and are cleared by rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- instruction_package gains OPCODE_WIDTH (3), INSTRUCTION_DATA_WIDTH, the opcode enum (ACCEPT, ACCEPT_PARTIAL, MATCH_CHAR, NOT_MATCH, MATCH_ANY, JMP, SPLIT) and the state typedef.
- One sub-module, regex_cpu_split_decoder: combinational decode of instruction, ch and eos into fields match, consume, accept, fork and jump.

Test Plan:
- ACCEPT_PARTIAL at pc 0x05 with lane 0 char 'a' -> accepts=1 exactly 4 cycles after the input handshake; no output pc.
- ACCEPT at pc 0x10: with end_of_string=0001 -> accepts=1; with 0000 -> accepts stays 0, back in IDLE.
- MATCH_CHAR 'b' at pc 0x1FF, lane 3 char 'b' -> output (pc 0x000, cc_id 0). With output_pc_ready held low 5 cycles, valid and data stay stable; input_pc_ready=0 throughout.
- SPLIT at pc 0x20 (t=0x40), then MATCH_ANY at 0x21 -> emit (0x40, cc 0), then fetch 0x21, then emit (0x22, cc 1).
- JMP-to-self at pc 0x30 -> exactly MAX_INTERNAL_STEPS (16) fetches of 0x30, no output, return to IDLE.
- Reset pulsed low while in EMIT -> output_pc_valid=0 immediately, input_pc_ready=1; the next thread runs normally.
